bus_owner_mux: RTL

Downstream consumer of the round-robin arbiter's one-hot `grant`. Latches the granted requester as bus owner and muxes that requester's address, write data, direction and burst length onto a single shared memory bus. Runs a valid/ready burst, returns per-beat acks and read data to the owner, then releases the bus. Outputs from the arbiter are only sampled while idle, so arbiter grant churn during a burst is harmless.

---
 rtl/bus_owner_mux.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bus_owner_mux.sv
// Bus owner mux: latches the arbiter's granted requester and runs its valid/ready burst on the shared bus.
// Optional GRANT_ONEHOT_CHECK_EN rejects multi-hot grants and raises a sticky err_onehot.
module bus_owner_mux #(
    parameter int NUM_REQ_MSB = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ_MSB:0]              req,
    input  logic [NUM_REQ_MSB:0]              grant,
    input  logic [(NUM_REQ_MSB+1)*ADDR_W-1:0] addr_in,
    input  logic [(NUM_REQ_MSB+1)*DATA_W-1:0] wdata_in,
    input  logic [NUM_REQ_MSB:0]              we_in,
    input  logic [(NUM_REQ_MSB+1)*4-1:0]      len_in,
    output logic                              bus_valid,
    output logic [ADDR_W-1:0]                 bus_addr,
    output logic [DATA_W-1:0]                 bus_wdata,
    output logic                              bus_we,
    input  logic                              bus_ready,
    input  logic [DATA_W-1:0]                 bus_rdata,
    output logic [NUM_REQ_MSB:0]              ack,
    output logic [DATA_W-1:0]                 rdata_out,
    output logic                              done,
    output logic                              busy,
    output logic                              err_onehot
);
    // state | meaning
    // IDLE  | bus free, sampling grant & req for a new owner
    // XFER  | presenting beats of the owner's burst
    // DONE  | one-cycle completion pulse, then back to IDLE
    localparam int NREQ  = NUM_REQ_MSB + 1;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ_MSB:0]   owner_q, owner_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   we_q, we_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             last_q, last_d;
    logic [NUM_REQ_MSB:0]   ack_q, ack_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ_MSB:0]   cand;
    logic [IDX_W-1:0]       cand_idx;
    logic                   start;
    logic                   handshake;

    assign cand = grant & req;

    // Lowest-index candidate wins; with a legal one-hot grant this is simply the granted requester.
    always_comb begin
        cand_idx = '0;
        for (int i = NUM_REQ_MSB; i >= 0; i--) begin
            if (cand[i]) cand_idx = IDX_W'(i);
        end
    end

`ifdef GRANT_ONEHOT_CHECK_EN
    localparam logic [NUM_REQ_MSB:0] GRANT_ONE = 1;
    logic multi_hot;
    logic err_q, err_d;

    assign multi_hot = (grant & (grant - GRANT_ONE)) != '0;
    assign start     = (state_q == IDLE) && (cand != '0) && !multi_hot;
    assign err_d     = err_q | ((state_q == IDLE) && multi_hot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_onehot = err_q;
`else
    assign start      = (state_q == IDLE) && (cand != '0);
    assign err_onehot = 1'b0;
`endif

    assign handshake = (state_q == XFER) && bus_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = XFER;
            XFER:    if (handshake && (cnt_q == last_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (start) begin
            owner_d           = '0;
            owner_d[cand_idx] = 1'b1;
            idx_d             = cand_idx;
            addr_d            = addr_in[cand_idx*ADDR_W +: ADDR_W];
            we_d              = we_in[cand_idx];
            cnt_d             = 4'd0;
            last_d            = len_in[cand_idx*4 +: 4];
        end else if (handshake) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + 4'd1;
        end
        ack_d   = handshake ? owner_q : '0;
        rdata_d = handshake ? bus_rdata : rdata_q;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= 4'd0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // Write data follows the owner's input live; reads drive zero.
    always_comb begin
        bus_valid = (state_q == XFER);
        bus_addr  = addr_q;
        bus_we    = (state_q == XFER) && we_q;
        bus_wdata = '0;
        if ((state_q == XFER) && we_q) bus_wdata = wdata_in[idx_q*DATA_W +: DATA_W];
        done      = (state_q == DONE);
    end

    assign ack       = ack_q;
    assign rdata_out = rdata_q;
    assign busy      = busy_q;

endmodule
